// File: rtl/issue_scalar_if.sv
// Dispatch, writeback, pipeline-control and issue-slot signals of the scalar issue stage.
// master = dispatch/execute side, slave = issue_scalar.
interface issue_scalar_if;
   logic        fust_en;
   logic [1:0]  fu_sel;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [31:0] in_imm;
   logic [1:0]  in_t1;
   logic [1:0]  in_t2;
   logic        wb_tag_valid;
   logic [1:0]  wb_tag;
   logic        flush;
   logic        freeze;
   logic        ex_ready;
   logic        issue_valid;
   logic [1:0]  issue_fu;
   logic [4:0]  issue_rd;
   logic [4:0]  issue_rs1;
   logic [4:0]  issue_rs2;
   logic [31:0] issue_imm;
   logic [2:0]  busy_vec;

   modport master (
      output fust_en, fu_sel, in_rd, in_rs1, in_rs2, in_imm, in_t1, in_t2,
      output wb_tag_valid, wb_tag, flush, freeze, ex_ready,
      input  issue_valid, issue_fu, issue_rd, issue_rs1, issue_rs2, issue_imm, busy_vec
   );

   modport slave (
      input  fust_en, fu_sel, in_rd, in_rs1, in_rs2, in_imm, in_t1, in_t2,
      input  wb_tag_valid, wb_tag, flush, freeze, ex_ready,
      output issue_valid, issue_fu, issue_rd, issue_rs1, issue_rs2, issue_imm, busy_vec
   );
endinterface

// File: rtl/issue_scalar.sv
// Three-row scalar FUST (ALU, LD_ST, BRANCH) with tag wakeup and oldest-ready select into one issue latch.
// Latency: insert to issue_valid in 2 edges; the latch holds while ex_ready=0 or freeze=1.
module issue_scalar (
   input  logic         CLK,
   input  logic         nRST,
   issue_scalar_if.slave bus
);
   logic [2:0]  busy_q;
   logic [4:0]  rd_q  [3];
   logic [4:0]  rs1_q [3];
   logic [4:0]  rs2_q [3];
   logic [31:0] imm_q [3];
   logic [1:0]  t1_q  [3];
   logic [1:0]  t2_q  [3];
   logic [1:0]  age_q [3];

   logic        iss_vld;
   logic [1:0]  iss_fu;
   logic [4:0]  iss_rd, iss_rs1, iss_rs2;
   logic [31:0] iss_imm;

   logic        sel_vld;
   logic [1:0]  sel_idx;
   logic [1:0]  sel_age;
   logic        ld, issue_go, ins, wake;
   logic [1:0]  new_t1, new_t2;
   logic [2:0]  row_ins;
   logic        any_ins;

   // Strict '>' keeps the lower-numbered row on equal age, giving ALU > LD_ST > BRANCH.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = 2'd0;
      sel_age = 2'd0;
      for (int i = 0; i < 3; i++) begin
         if (busy_q[i] && t1_q[i] == 2'd0 && t2_q[i] == 2'd0 && (!sel_vld || age_q[i] > sel_age)) begin
            sel_vld = 1'b1;
            sel_idx = 2'(i);
            sel_age = age_q[i];
         end
      end
   end

   assign ld       = (!iss_vld || bus.ex_ready) && !bus.freeze;
   assign issue_go = ld && sel_vld;
   assign ins      = bus.fust_en && bus.fu_sel != 2'd3 && !bus.flush;
   assign wake     = bus.wb_tag_valid && bus.wb_tag != 2'd0;
   assign new_t1   = (wake && bus.in_t1 == bus.wb_tag) ? 2'd0 : bus.in_t1;
   assign new_t2   = (wake && bus.in_t2 == bus.wb_tag) ? 2'd0 : bus.in_t2;

   // A row accepts an insert when free or when it is leaving through the issue latch this edge.
   always_comb begin
      row_ins = 3'b000;
      for (int i = 0; i < 3; i++) begin
         row_ins[i] = ins && bus.fu_sel == 2'(i) && (!busy_q[i] || (issue_go && sel_idx == 2'(i)));
      end
   end
   assign any_ins = |row_ins;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         busy_q  <= 3'b000;
         iss_vld <= 1'b0;
         iss_fu  <= 2'd0;
         iss_rd  <= 5'd0;
         iss_rs1 <= 5'd0;
         iss_rs2 <= 5'd0;
         iss_imm <= 32'd0;
         for (int i = 0; i < 3; i++) begin
            rd_q[i]  <= 5'd0;
            rs1_q[i] <= 5'd0;
            rs2_q[i] <= 5'd0;
            imm_q[i] <= 32'd0;
            t1_q[i]  <= 2'd0;
            t2_q[i]  <= 2'd0;
            age_q[i] <= 2'd0;
         end
      end else if (bus.flush) begin
         busy_q  <= 3'b000;
         iss_vld <= 1'b0;
      end else begin
         if (ld) begin
            iss_vld <= sel_vld;
            if (sel_vld) begin
               iss_fu  <= sel_idx;
               iss_rd  <= rd_q[sel_idx];
               iss_rs1 <= rs1_q[sel_idx];
               iss_rs2 <= rs2_q[sel_idx];
               iss_imm <= imm_q[sel_idx];
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (row_ins[i]) begin
               busy_q[i] <= 1'b1;
               rd_q[i]   <= bus.in_rd;
               rs1_q[i]  <= bus.in_rs1;
               rs2_q[i]  <= bus.in_rs2;
               imm_q[i]  <= bus.in_imm;
               t1_q[i]   <= new_t1;
               t2_q[i]   <= new_t2;
               age_q[i]  <= 2'd0;
            end else begin
               if (issue_go && sel_idx == 2'(i))
                  busy_q[i] <= 1'b0;
               if (busy_q[i] && wake && t1_q[i] == bus.wb_tag)
                  t1_q[i] <= 2'd0;
               if (busy_q[i] && wake && t2_q[i] == bus.wb_tag)
                  t2_q[i] <= 2'd0;
               if (busy_q[i] && any_ins && age_q[i] != 2'd3)
                  age_q[i] <= age_q[i] + 2'd1;
            end
         end
      end
   end

   assign bus.issue_valid = iss_vld;
   assign bus.issue_fu    = iss_fu;
   assign bus.issue_rd    = iss_rd;
   assign bus.issue_rs1   = iss_rs1;
   assign bus.issue_rs2   = iss_rs2;
   assign bus.issue_imm   = iss_imm;
   assign bus.busy_vec    = busy_q;
endmodule
